// File: rtl/mmr_bus_arbiter_pkg.sv
// Shared definitions for the MMR bus arbiter: FSM state encoding, default
// bus dimensions and an index-width helper.
package mmr_bus_arbiter_pkg;

  localparam int unsigned DEF_NREQ       = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmr_bus_arbiter_rr_pick.sv
// Round-robin winner selection (combinational).
// Ports:
//   req        - request vector
//   last       - index of the most recent winner; search starts at last+1
//   win_onehot - one-hot winner (zero when no request)
//   win_idx    - winner index
//   win_valid  - at least one request present
module mmr_bus_arbiter_rr_pick
  import mmr_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_onehot,
  output logic [IW-1:0]   win_idx,
  output logic            win_valid
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    win_valid  = |req;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (req[(int'(last) + k) % int'(NREQ)]) begin
        win_idx = IW'((int'(last) + k) % int'(NREQ));
      end
    end
    if (win_valid) begin
      win_onehot = NREQ'(1) << win_idx;
    end
  end

endmodule

// File: rtl/mmr_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped-register bus between NREQ
// requesters. One single-word transaction per grant: IDLE -> XFER -> DONE.
// Optional macro MMR_BUS_ARBITER_LOCK_EN adds a lock input that lets the last
// owner keep the bus for atomic read-modify-write sequences.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   req/rw_in             - per-requester request and direction (1=write)
//   addr_in/wdata_in      - flattened per-requester address / write data
//   lock                  - (LOCK_EN only) hold the bus for the owner
//   gnt/ack               - one-hot grant (XFER+DONE) and completion pulse
//   rdata                 - data of the last completed read
//   bus_enable/rw/addr    - bus control, high/valid during XFER
//   bus_data              - tristate data, driven only for writes in XFER
module mmr_bus_arbiter
  import mmr_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            rw_in,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr_in,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata_in,
`ifdef MMR_BUS_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]            lock,
`endif
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       bus_enable,
  output logic                       bus_rw,
  output logic [ADDR_WIDTH-1:0]      bus_addr,
  inout  wire  [DATA_WIDTH-1:0]      bus_data
);

  localparam int unsigned IW = idx_width(NREQ);

  arb_state_e            state_q, state_d;
  logic [NREQ-1:0]       gnt_d, ack_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  bus_enable_d, bus_rw_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         widx_q, widx_d;

  logic [NREQ-1:0]       pick_onehot, sel_onehot;
  logic [IW-1:0]         pick_idx, sel_idx;
  logic                  pick_valid, take, upd_last;

`ifdef MMR_BUS_ARBITER_LOCK_EN
  logic                  lock_flag_q, lock_flag_d;
  logic [IW-1:0]         lock_owner_q, lock_owner_d;
`endif

  mmr_bus_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (req),
    .last       (last_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Write data goes on the bus only during a write XFER cycle.
  assign bus_data = (bus_enable && bus_rw) ? wdata_q : {DATA_WIDTH{1'bz}};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      bus_enable <= 1'b0;
      bus_rw     <= 1'b0;
      bus_addr   <= '0;
      wdata_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      widx_q     <= '0;
`ifdef MMR_BUS_ARBITER_LOCK_EN
      lock_flag_q  <= 1'b0;
      lock_owner_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt        <= gnt_d;
      ack        <= ack_d;
      rdata      <= rdata_d;
      bus_enable <= bus_enable_d;
      bus_rw     <= bus_rw_d;
      bus_addr   <= bus_addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      widx_q     <= widx_d;
`ifdef MMR_BUS_ARBITER_LOCK_EN
      lock_flag_q  <= lock_flag_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt;
    ack_d        = ack;
    rdata_d      = rdata;
    bus_enable_d = bus_enable;
    bus_rw_d     = bus_rw;
    bus_addr_d   = bus_addr;
    wdata_d      = wdata_q;
    last_d       = last_q;
    widx_d       = widx_q;
    sel_idx      = pick_idx;
    sel_onehot   = pick_onehot;
    take         = pick_valid;
    upd_last     = 1'b1;
`ifdef MMR_BUS_ARBITER_LOCK_EN
    lock_flag_d  = lock_flag_q;
    lock_owner_d = lock_owner_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef MMR_BUS_ARBITER_LOCK_EN
        // A held lock overrides round-robin; a dropped owner request frees it.
        if (lock_flag_q) begin
          if (req[lock_owner_q]) begin
            take       = 1'b1;
            sel_idx    = lock_owner_q;
            sel_onehot = NREQ'(1) << lock_owner_q;
            upd_last   = 1'b0;
          end else begin
            lock_flag_d = 1'b0;
          end
        end
`endif
        if (take) begin
          state_d      = XFER;
          gnt_d        = sel_onehot;
          widx_d       = sel_idx;
          bus_enable_d = 1'b1;
          bus_rw_d     = rw_in[sel_idx];
          bus_addr_d   = addr_in[int'(sel_idx)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
          wdata_d      = wdata_in[int'(sel_idx)*int'(DATA_WIDTH) +: DATA_WIDTH];
          if (upd_last) begin
            last_d = sel_idx;
          end
        end
      end
      XFER: begin
        state_d      = DONE;
        bus_enable_d = 1'b0;
        ack_d        = gnt;
        if (!bus_rw) begin
          rdata_d = bus_data;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ack_d   = '0;
`ifdef MMR_BUS_ARBITER_LOCK_EN
        if (lock[widx_q]) begin
          lock_flag_d  = 1'b1;
          lock_owner_d = widx_q;
        end
`endif
      end
      default: begin
        state_d      = IDLE;
        gnt_d        = '0;
        ack_d        = '0;
        bus_enable_d = 1'b0;
      end
    endcase
  end

endmodule
